mvm_result_drain: RTL and testbench
===================================

MVM_RESULT_DRAIN -- requirements
Module: mvm_result_drain

Interface
REQ-001 SHALL have parameter OWIDTH, default 32, width of each result word.
REQ-002 SHALL have parameter NUM_OLANES, default 8, number of result lanes per bundle.
REQ-003 SHALL have parameter DEPTH, default 4, bundle FIFO capacity, power of 2, >=2.
REQ-004 SHALL have port clk, input, 1, the block's single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port i_result, input, OWIDTH x [0:NUM_OLANES-1] unpacked, result bundle from the MVM accumulators.
REQ-007 SHALL have port i_valid, input, 1, single-cycle strobe marking i_result valid.
REQ-008 SHALL have port o_data, output, OWIDTH, current serialized result word.
REQ-009 SHALL have port o_lane, output, $clog2(NUM_OLANES), lane index of o_data.
REQ-010 SHALL have port o_last, output, 1, high when o_lane == NUM_OLANES-1 and o_valid is high.
REQ-011 SHALL have port o_valid, output, 1, o_data is presentable.
REQ-012 SHALL have port i_ready, input, 1, downstream accepts o_data.
REQ-013 SHALL have port o_full, output, 1, FIFO holds DEPTH bundles.
REQ-014 SHALL have port o_overflow, output, 1, sticky flag for a dropped bundle.

Function
REQ-015 SHALL store bundles in a DEPTH-entry register FIFO with write pointer, read pointer, and an occupancy count of width $clog2(DEPTH)+1.
REQ-016 SHALL capture all NUM_OLANES words of i_result into the write entry on any edge where i_valid=1 and the bundle is accepted.
REQ-017 SHALL accept a bundle when count<DEPTH, or when count==DEPTH and the last-lane word is transferred in the same cycle.
REQ-018 SHALL otherwise drop the bundle, leave FIFO contents unchanged, and set o_overflow=1 on the next edge.
REQ-019 SHALL assert o_valid combinationally whenever count>0, making o_valid high in the cycle after the capturing edge (1-cycle latency, first-word fall-through).
REQ-020 SHALL drive o_data with lane o_lane of the head bundle while o_valid=1, and drive 0 while o_valid=0.
REQ-021 SHALL define a transfer as o_valid && i_ready at a rising edge.
REQ-022 SHALL hold o_data, o_lane and o_last stable while o_valid=1 and i_ready=0.
REQ-023 SHALL use a two-state FSM: IDLE (count==0, lane=0) and DRAIN (count>0).
REQ-024 SHALL increment the lane counter on each transfer with lane<NUM_OLANES-1.
REQ-025 SHALL, on a transfer at lane NUM_OLANES-1, reset the lane counter to 0, advance the read pointer modulo DEPTH, and decrement count.
REQ-026 SHALL, on a simultaneous accepted write and last-lane transfer, leave count unchanged while both pointers advance.
REQ-027 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-028 SHALL transition DRAIN->IDLE only when the final lane of the last stored bundle transfers with no write that cycle.
REQ-029 SHALL never emit words from a partially written bundle; bundle capture SHALL be atomic.
REQ-030 SHALL sustain one word per cycle when i_ready is held at 1, with no bubble between bundles.

Reset
REQ-031 SHALL, while rst=1 and asynchronously on its assertion, clear pointers, count, lane counter and o_overflow, and place the FSM in IDLE.
REQ-032 SHALL therefore show o_valid=0, o_data=0, o_lane=0, o_last=0, o_full=0 and o_overflow=0 during reset.
REQ-033 SHALL, on reset mid-drain, discard all stored bundles and emit nothing until the next accepted bundle.
REQ-034 SHALL ignore i_valid on any edge while rst=1.
REQ-035 SHALL NOT require the FIFO data registers to be reset.

Verification
REQ-036 SHALL cover single bundle: i_result={1..8}, i_valid pulse, i_ready=1 -> o_data 1..8 on 8 consecutive cycles, o_lane 0..7, o_last on the 8th only, then o_valid=0.
REQ-037 SHALL cover backpressure: i_ready toggled 1,0,0,1,... -> no duplicated or skipped words, and o_data stable during stalls.
REQ-038 SHALL cover full/overflow: 5 bundles with i_ready=0 at DEPTH=4 -> o_full=1, o_overflow=1, and only bundles 1-4 emitted, in order.
REQ-039 SHALL cover simultaneous events: full FIFO, new bundle on the last-lane transfer cycle -> bundle accepted, o_overflow stays 0, o_full stays 1.
REQ-040 SHALL cover wrap-around: 10 bundles streamed with i_ready=1 -> 80 words in order, pointers wrap, no bubbles.
REQ-041 SHALL cover reset mid-drain: rst asserted at lane 3 of 2 stored bundles -> o_valid=0 immediately, and the next bundle is emitted starting at lane 0.

Source files
------------

// File: rtl/mvm_result_drain.sv
// mvm_result_drain: buffers full result bundles from the MVM accumulators in a
// small register FIFO and serializes them one word per cycle, lane 0 first,
// with valid/ready handshaking and a sticky flag for dropped bundles.
module mvm_result_drain #(
  parameter int OWIDTH     = 32,
  parameter int NUM_OLANES = 8,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [OWIDTH-1:0]             i_result [0:NUM_OLANES-1],
  input  logic                          i_valid,
  output logic [OWIDTH-1:0]             o_data,
  output logic [$clog2(NUM_OLANES)-1:0] o_lane,
  output logic                          o_last,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_full,
  output logic                          o_overflow
);

  localparam int LW = $clog2(NUM_OLANES);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [LW-1:0] LAST_LANE  = LW'(NUM_OLANES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE        = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [OWIDTH-1:0] mem [DEPTH][NUM_OLANES];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [LW-1:0]     lane;

  logic              xfer;
  logic              last_xfer;
  logic              accept;

  assign xfer      = o_valid & i_ready;
  assign last_xfer = xfer & (lane == LAST_LANE);
  // A full FIFO still takes a new bundle when the head bundle frees its slot
  // in the same cycle.
  assign accept    = i_valid & ((count != FULL_COUNT) | last_xfer);

  // Bundle storage: all lanes are written together, so capture is atomic.
  // NOTE: data registers carry no reset; pointers and count decide what is
  // visible, so stale contents are never emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_OLANES; i++) begin
        mem[wr_ptr][i] <= i_result[i];
      end
    end
  end

  // Pointers, occupancy, lane counter and sticky overflow flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lane       <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (last_xfer) begin
        rd_ptr <= rd_ptr + PW'(1);
        lane   <= '0;
      end else if (xfer) begin
        lane <= lane + LW'(1);
      end
      case ({accept, last_xfer})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (i_valid && !accept) begin
        o_overflow <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave DRAIN only when the last stored bundle finishes and
  // nothing new arrives in that cycle.
  // NOTE: every combinational output gets a default first so no path can
  // infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DRAIN;
      DRAIN:   if (last_xfer && !accept && (count == ONE)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: head bundle word at the current lane, zero while empty.
  always_comb begin
    o_valid = (state == DRAIN);
    o_lane  = lane;
    o_last  = 1'b0;
    o_data  = '0;
    o_full  = (count == FULL_COUNT);
    if (o_valid) begin
      o_last = (lane == LAST_LANE);
      o_data = mem[rd_ptr][lane];
    end
  end

endmodule

// File: tb/tb_mvm_result_drain.sv
// tb_mvm_result_drain: directed scenarios plus randomized traffic, checked
// every cycle against a queue-of-bundles reference model.
module tb_mvm_result_drain;

  localparam int OWIDTH     = 32;
  localparam int NUM_OLANES = 8;
  localparam int DEPTH      = 4;
  localparam int LW         = $clog2(NUM_OLANES);

  typedef logic [NUM_OLANES-1:0][OWIDTH-1:0] bundle_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [OWIDTH-1:0] i_result [0:NUM_OLANES-1];
  logic              i_valid = 1'b0;
  logic              i_ready = 1'b0;
  logic [OWIDTH-1:0] o_data;
  logic [LW-1:0]     o_lane;
  logic              o_last;
  logic              o_valid;
  logic              o_full;
  logic              o_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;

  // Reference model: stored bundles in arrival order, lane of the head word,
  // sticky overflow.
  bundle_t mq[$];
  int      m_lane = 0;
  bit      m_ovf  = 1'b0;

  mvm_result_drain #(
    .OWIDTH    (OWIDTH),
    .NUM_OLANES(NUM_OLANES),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_result  (i_result),
    .i_valid   (i_valid),
    .o_data    (o_data),
    .o_lane    (o_lane),
    .o_last    (o_last),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_full    (o_full),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bundle_t seq_bundle(input int base);
    bundle_t b;
    for (int i = 0; i < NUM_OLANES; i++) b[i] = OWIDTH'(base + i);
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    for (int i = 0; i < NUM_OLANES; i++) b[i] = $urandom;
    return b;
  endfunction

  // One clock: drive inputs at the falling edge, compare outputs against the
  // model, then let the rising edge happen and advance the model.
  task automatic cycle(input bit v, input bit r, input bundle_t b);
    bit      e_valid;
    bit      xfer;
    bit      lastx;
    bit      acc;
    logic [OWIDTH-1:0] e_data;
    @(negedge clk);
    i_valid = v;
    i_ready = r;
    for (int i = 0; i < NUM_OLANES; i++) i_result[i] = b[i];
    #1;
    e_valid = (mq.size() > 0);
    e_data  = e_valid ? mq[0][m_lane] : '0;
    check("o_valid", o_valid, e_valid);
    check("o_data", o_data, e_data);
    check("o_lane", o_lane, e_valid ? m_lane : 0);
    check("o_last", o_last, e_valid && (m_lane == NUM_OLANES - 1));
    check("o_full", o_full, mq.size() == DEPTH);
    check("o_overflow", o_overflow, m_ovf);
    @(posedge clk);
    xfer  = e_valid && r;
    lastx = xfer && (m_lane == NUM_OLANES - 1);
    acc   = v && ((mq.size() < DEPTH) || lastx);
    if (xfer) n_words++;
    if (lastx) begin
      void'(mq.pop_front());
      m_lane = 0;
    end else if (xfer) begin
      m_lane++;
    end
    if (acc) mq.push_back(b);
    else if (v) m_ovf = 1'b1;
  endtask

  // Reset asserted between edges; i_valid is held high while in reset and
  // must be ignored.
  task automatic do_reset();
    #2;
    rst     = 1'b1;
    i_valid = 1'b1;
    i_ready = 1'b1;
    #1;
    check("rst o_valid", o_valid, 1'b0);
    check("rst o_data", o_data, '0);
    check("rst o_lane", o_lane, '0);
    check("rst o_last", o_last, 1'b0);
    check("rst o_full", o_full, 1'b0);
    check("rst o_overflow", o_overflow, 1'b0);
    mq.delete();
    m_lane = 0;
    m_ovf  = 1'b0;
    @(posedge clk);
    #1;
    check("rst held o_valid", o_valid, 1'b0);
    @(negedge clk);
    rst     = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
  endtask

  initial begin
    bundle_t zero_b;
    int      w0;
    int      k;
    bit      bp_pat [4];
    zero_b = '0;
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < NUM_OLANES; i++) i_result[i] = '0;

    // Single bundle 1..8 drained at full rate.
    do_reset();
    w0 = n_words;
    cycle(1'b1, 1'b1, seq_bundle(1));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, zero_b);
    check("single words", n_words - w0, NUM_OLANES);

    // Backpressure pattern 1,0,0,1 over two bundles.
    do_reset();
    cycle(1'b1, 1'b0, seq_bundle(16'h100));
    cycle(1'b1, 1'b0, seq_bundle(16'h200));
    for (int i = 0; i < 40; i++) cycle(1'b0, bp_pat[i % 4], zero_b);
    check("backpressure drained", o_valid, 1'b0);

    // Five bundles into a four-deep FIFO with the sink stalled.
    do_reset();
    w0 = n_words;
    for (int b = 0; b < 5; b++) cycle(1'b1, 1'b0, seq_bundle(16 * b + 1));
    #2;
    check("ovf o_full", o_full, 1'b1);
    check("ovf o_overflow", o_overflow, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, zero_b);
    check("ovf words", n_words - w0, DEPTH * NUM_OLANES);

    // Full FIFO receives a bundle on the head's last-lane transfer.
    do_reset();
    for (int b = 0; b < DEPTH; b++) cycle(1'b1, 1'b0, rand_bundle());
    k = 0;
    while (m_lane != NUM_OLANES - 1 && k < 16) begin
      cycle(1'b0, 1'b1, zero_b);
      k++;
    end
    #2;
    check("simul at last lane", o_last, 1'b1);
    cycle(1'b1, 1'b1, rand_bundle());
    #2;
    check("simul o_full", o_full, 1'b1);
    check("simul o_overflow", o_overflow, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, zero_b);

    // Ten bundles streamed back to back: pointers wrap, no bubbles.
    do_reset();
    w0 = n_words;
    for (int i = 0; i < 10 * NUM_OLANES; i++)
      cycle((i % NUM_OLANES) == 0, 1'b1, seq_bundle(1000 + i));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, zero_b);
    check("wrap words", n_words - w0, 10 * NUM_OLANES);

    // Reset while draining lane 3 of two stored bundles.
    do_reset();
    cycle(1'b1, 1'b0, seq_bundle(16'h500));
    cycle(1'b1, 1'b0, seq_bundle(16'h600));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, zero_b);
    #2;
    check("mid-drain lane", o_lane, 3);
    do_reset();
    cycle(1'b1, 1'b1, seq_bundle(16'h700));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, zero_b);

    // Randomized traffic, occasionally bursty enough to overflow.
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 2, $urandom_range(0, 3) != 0, rand_bundle());
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, zero_b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
